cmp_result_tracker: RTL and testbench
=====================================

// Module: cmp_result_tracker
// PURPOSE
//   Downstream stage of the 4-bit magnitude comparator. Samples its lower/equal/greater
//   flags when in_valid is high and keeps saturating per-class counters. Tracks the last
//   result class, pulses on a class change and flags runs of consecutive equal results.
//   Flag combinations that are not one-hot are rejected and latched as an error.
// PARAMETERS
//   CNT_W    8   width of each per-class counter (saturating)
//   RUN_LEN  4   consecutive equal samples needed to assert eq_run (range 1..255)
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   in_valid     in   1      lower/equal/greater are valid this cycle
//   lower        in   1      comparator A<B
//   equal        in   1      comparator A==B
//   greater      in   1      comparator A>B
//   clr          in   1      synchronous clear of counters/state/error
//   lt_count     out  CNT_W  number of accepted lower samples
//   eq_count     out  CNT_W  number of accepted equal samples
//   gt_count     out  CNT_W  number of accepted greater samples
//   last_result  out  2      00 none, 01 lower, 10 equal, 11 greater
//   change       out  1      one-cycle pulse: accepted class differs from previous class
//   eq_run       out  1      high while the equal run length is >= RUN_LEN
//   error        out  1      sticky: a valid sample was not one-hot
//   hist         out  8      last 4 accepted classes, newest in [1:0] (see CONFIGURATION)
// BEHAVIOUR
//   - Clocking and reset: one clock. Reset is asynchronous and active-high. All outputs
//     are registered. Reset drives every output to 0, including hist.
//   - FSM states: NONE, LT, EQ, GT. Reset and clr enter NONE. Each accepted sample moves
//     the FSM to the sample's class. last_result is the state encoding.
//   - Accept rule: a sample is accepted when in_valid=1 and exactly one flag is 1.
//     A valid sample that is not one-hot (000, 011, 111, ...) is dropped:
//     error is set, counters and state are unchanged, and change does not pulse.
//   - Latency: outputs reflect an accepted sample one cycle after the sampling edge.
//     in_valid may be high on consecutive cycles; every cycle is a sample.
//   - Counters: the matching counter increments by 1 and holds at 2^CNT_W-1.
//     It does not wrap.
//   - change: asserts for 1 cycle when an accepted class differs from the current
//     non-NONE state. It never pulses on the first sample taken out of NONE.
//   - Equal run: an internal 8-bit run counter increments on each accepted equal
//     sample and saturates at 255. Any accepted lower or greater sample sets it to 0.
//     eq_run = (run >= RUN_LEN). Dropped samples and idle cycles leave the run unchanged.
//   - clr: takes effect at the next edge. It zeroes the counters, run, change, error and
//     hist, and enters NONE. clr has priority over an in_valid in the same cycle; that
//     sample is discarded.
//   - Reset mid-stream: outputs are cleared asynchronously; no partial update survives.
// CONFIGURATION
//   CMP_TRACK_HIST_EN defined: on each accepted sample, hist <= {hist[5:0], class code}.
//     Reset and clr zero hist.
//   CMP_TRACK_HIST_EN undefined: no history register is built. hist is tied to 8'h00.
//     All other behaviour is identical.
// TESTING
//   1. Reset, then lower,lower,greater (valid each cycle) -> lt=2, gt=1, eq=0,
//      last_result=11, change pulses once, on the cycle after greater.
//   2. Equal x4 with RUN_LEN=4 -> eq_run rises 1 cycle after the 4th sample.
//      Then 1 greater -> eq_run falls and change pulses.
//   3. in_valid with flags 011 -> error=1, counters and last_result unchanged.
//      A following legal sample is still counted; error stays 1.
//   4. With CNT_W=4, apply 20 lower samples -> lt_count holds at 15. Then clr together
//      with a valid equal -> all counts 0, last_result=00, eq_count=0.
//   5. With CMP_TRACK_HIST_EN, apply lt,eq,gt,eq -> hist=8'b01_10_11_10.
//      Without the macro, hist stays 8'h00.
//   6. Assert rst mid-run (eq_run=1, counts nonzero) -> all outputs 0 immediately,
//      without waiting for a clock edge.

Source files
------------

// File: rtl/cmp_result_tracker_if.sv
// Bus between the magnitude comparator and its result tracker: sample flags in,
// registered statistics out.
interface cmp_result_tracker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             lower;
  logic             equal;
  logic             greater;
  logic             clr;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] gt_count;
  logic [1:0]       last_result;
  logic             change;
  logic             eq_run;
  logic             error;
  logic [7:0]       hist;

  modport master (
    output in_valid, lower, equal, greater, clr,
    input  lt_count, eq_count, gt_count, last_result, change, eq_run, error, hist
  );

  modport slave (
    input  in_valid, lower, equal, greater, clr,
    output lt_count, eq_count, gt_count, last_result, change, eq_run, error, hist
  );
endinterface

// File: rtl/cmp_result_tracker.sv
// Result tracker behind the 4-bit magnitude comparator: per-class saturating counts,
// last class, change pulse, equal-run flag and sticky one-hot error.
// Optional CMP_TRACK_HIST_EN builds the 4-deep class history register on hist.
module cmp_result_tracker #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_tracker_if.slave  trk_if
);

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_LT   = 2'b01,
    ST_EQ   = 2'b10,
    ST_GT   = 2'b11
  } state_e;

  localparam int unsigned      RUN_W   = 8;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_THR = RUN_W'(RUN_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             change_q, change_d;
  logic             eq_run_q, eq_run_d;
  logic             error_q, error_d;

  state_e           cls_c;
  logic             onehot_c;
  logic             accept_c;
  logic             reject_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Classify the incoming flags; anything other than exactly one set is illegal.
  always_comb begin
    cls_c    = ST_NONE;
    onehot_c = 1'b0;
    case ({trk_if.lower, trk_if.equal, trk_if.greater})
      3'b100:  begin cls_c = ST_LT; onehot_c = 1'b1; end
      3'b010:  begin cls_c = ST_EQ; onehot_c = 1'b1; end
      3'b001:  begin cls_c = ST_GT; onehot_c = 1'b1; end
      default: begin cls_c = ST_NONE; onehot_c = 1'b0; end
    endcase
    accept_c = trk_if.in_valid & onehot_c;
    reject_c = trk_if.in_valid & ~onehot_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trk_if.clr) begin
      state_d = ST_NONE;
    end else if (accept_c) begin
      state_d = cls_c;
    end
  end

  // Next values of the registered outputs; clr wins over a same-cycle sample.
  always_comb begin
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    run_d    = run_q;
    change_d = 1'b0;
    error_d  = error_q;
    if (trk_if.clr) begin
      lt_d    = '0;
      eq_d    = '0;
      gt_d    = '0;
      run_d   = '0;
      error_d = 1'b0;
    end else begin
      if (accept_c) begin
        change_d = (state_q != ST_NONE) && (cls_c != state_q);
        case (cls_c)
          ST_LT: begin
            lt_d  = sat_inc(lt_q);
            run_d = '0;
          end
          ST_EQ: begin
            eq_d  = sat_inc(eq_q);
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
          end
          ST_GT: begin
            gt_d  = sat_inc(gt_q);
            run_d = '0;
          end
          default: begin
            run_d = run_q;
          end
        endcase
      end
      if (reject_c) begin
        error_d = 1'b1;
      end
    end
    eq_run_d = (run_d >= RUN_THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_q     <= '0;
      eq_q     <= '0;
      gt_q     <= '0;
      run_q    <= '0;
      change_q <= 1'b0;
      eq_run_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      run_q    <= run_d;
      change_q <= change_d;
      eq_run_q <= eq_run_d;
      error_q  <= error_d;
    end
  end

  assign trk_if.lt_count    = lt_q;
  assign trk_if.eq_count    = eq_q;
  assign trk_if.gt_count    = gt_q;
  assign trk_if.last_result = state_q;
  assign trk_if.change      = change_q;
  assign trk_if.eq_run      = eq_run_q;
  assign trk_if.error       = error_q;

`ifdef CMP_TRACK_HIST_EN
  logic [7:0] hist_q, hist_d;

  // Shift in the accepted class code, newest in the low bits.
  always_comb begin
    hist_d = hist_q;
    if (trk_if.clr) begin
      hist_d = 8'h00;
    end else if (accept_c) begin
      hist_d = {hist_q[5:0], cls_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 8'h00;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign trk_if.hist = hist_q;
`else
  assign trk_if.hist = 8'h00;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker: directed samples queue hand-computed
// expectations, a negedge monitor retires them one cycle after the sampling edge.
module tb_cmp_result_tracker;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned RUN_LEN = 4;

  typedef struct {
    string            name;
    int unsigned      cyc;
    logic [CNT_W-1:0] lt;
    logic [CNT_W-1:0] eq;
    logic [CNT_W-1:0] gt;
    logic [1:0]       last;
    logic             chg;
    logic             run;
    logic             err;
    logic [7:0]       hist;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmp_result_tracker_if #(.CNT_W(CNT_W)) trk_if();

  cmp_result_tracker #(
    .CNT_W   (CNT_W),
    .RUN_LEN (RUN_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trk_if (trk_if)
  );

  function automatic logic [7:0] hist_exp(input logic [7:0] h);
`ifdef CMP_TRACK_HIST_EN
    return h;
`else
    return 8'h00 & h;
`endif
  endfunction

  function automatic void check_snap(input exp_t e);
    n_checks++;
    if (trk_if.lt_count !== e.lt || trk_if.eq_count !== e.eq || trk_if.gt_count !== e.gt ||
        trk_if.last_result !== e.last || trk_if.change !== e.chg || trk_if.eq_run !== e.run ||
        trk_if.error !== e.err || trk_if.hist !== e.hist) begin
      n_fail++;
      $display("FAIL %s: got lt=%0d eq=%0d gt=%0d last=%b chg=%b run=%b err=%b hist=%h, expected lt=%0d eq=%0d gt=%0d last=%b chg=%b run=%b err=%b hist=%h",
               e.name, trk_if.lt_count, trk_if.eq_count, trk_if.gt_count, trk_if.last_result,
               trk_if.change, trk_if.eq_run, trk_if.error, trk_if.hist,
               e.lt, e.eq, e.gt, e.last, e.chg, e.run, e.err, e.hist);
    end
  endfunction

  function automatic exp_t zero_exp(input string name);
    exp_t e;
    e.name = name; e.cyc = 0;
    e.lt = '0; e.eq = '0; e.gt = '0; e.last = 2'b00;
    e.chg = 1'b0; e.run = 1'b0; e.err = 1'b0; e.hist = 8'h00;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the next edge.
  task automatic step(input string name, input logic v, input logic l, input logic eq_f,
                      input logic g, input logic c,
                      input logic [CNT_W-1:0] elt, input logic [CNT_W-1:0] eeq,
                      input logic [CNT_W-1:0] egt, input logic [1:0] el,
                      input logic ech, input logic erun, input logic eerr,
                      input logic [7:0] eh);
    exp_t e;
    @(posedge clk);
    #2;
    trk_if.in_valid = v;
    trk_if.lower    = l;
    trk_if.equal    = eq_f;
    trk_if.greater  = g;
    trk_if.clr      = c;
    e.name = name; e.cyc = cyc + 1;
    e.lt = elt; e.eq = eeq; e.gt = egt; e.last = el;
    e.chg = ech; e.run = erun; e.err = eerr; e.hist = hist_exp(eh);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d not retired until cycle %0d",
                   mon_e.name, mon_e.cyc, cyc);
        end else begin
          check_snap(mon_e);
        end
      end
    end
  end

  initial begin
    logic [7:0]       hh;
    logic [CNT_W-1:0] lc;
    trk_if.in_valid = 1'b0;
    trk_if.lower    = 1'b0;
    trk_if.equal    = 1'b0;
    trk_if.greater  = 1'b0;
    trk_if.clr      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_snap(zero_exp("reset_state"));
    rst = 1'b0;

    //    name         v l e g c  lt eq gt last chg run err hist
    step("l1",        1,1,0,0,0, 1, 0, 0, 2'b01, 0, 0, 0, 8'h01);
    step("l2",        1,1,0,0,0, 2, 0, 0, 2'b01, 0, 0, 0, 8'h05);
    step("g1",        1,0,0,1,0, 2, 0, 1, 2'b11, 1, 0, 0, 8'h17);
    step("idle1",     0,0,0,0,0, 2, 0, 1, 2'b11, 0, 0, 0, 8'h17);
    step("e1",        1,0,1,0,0, 2, 1, 1, 2'b10, 1, 0, 0, 8'h5E);
    step("e2",        1,0,1,0,0, 2, 2, 1, 2'b10, 0, 0, 0, 8'h7A);
    step("e3",        1,0,1,0,0, 2, 3, 1, 2'b10, 0, 0, 0, 8'hEA);
    step("e4_run",    1,0,1,0,0, 2, 4, 1, 2'b10, 0, 1, 0, 8'hAA);
    step("g_endrun",  1,0,0,1,0, 2, 4, 2, 2'b11, 1, 0, 0, 8'hAB);
    step("bad011",    1,0,1,1,0, 2, 4, 2, 2'b11, 0, 0, 1, 8'hAB);
    step("l_after",   1,1,0,0,0, 3, 4, 2, 2'b01, 1, 0, 1, 8'hAD);
    step("e5",        1,0,1,0,0, 3, 5, 2, 2'b10, 1, 0, 1, 8'hB6);
    step("e6",        1,0,1,0,0, 3, 6, 2, 2'b10, 0, 0, 1, 8'hDA);
    step("e7",        1,0,1,0,0, 3, 7, 2, 2'b10, 0, 0, 1, 8'h6A);
    step("bad111",    1,1,1,1,0, 3, 7, 2, 2'b10, 0, 0, 1, 8'h6A);
    step("bad000",    1,0,0,0,0, 3, 7, 2, 2'b10, 0, 0, 1, 8'h6A);
    step("e8_run",    1,0,1,0,0, 3, 8, 2, 2'b10, 0, 1, 1, 8'hAA);
    step("clr",       0,0,0,0,1, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00);

    hh = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      hh = {hh[5:0], 2'b01};
      lc = (k > 15) ? CNT_W'(15) : CNT_W'(k);
      step("sat_lt",  1,1,0,0,0, lc, 0, 0, 2'b01, 0, 0, 0, hh);
    end

    step("clr_eq",    1,0,1,0,1, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00);
    step("e_none",    1,0,1,0,0, 0, 1, 0, 2'b10, 0, 0, 0, 8'h02);
    step("e_b",       1,0,1,0,0, 0, 2, 0, 2'b10, 0, 0, 0, 8'h0A);
    step("e_c",       1,0,1,0,0, 0, 3, 0, 2'b10, 0, 0, 0, 8'h2A);
    step("e_d_run",   1,0,1,0,0, 0, 4, 0, 2'b10, 0, 1, 0, 8'hAA);
    step("idle2",     0,0,0,0,0, 0, 4, 0, 2'b10, 0, 1, 0, 8'hAA);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
      exp_q.delete();
    end

    // Reset lands between edges; outputs must clear without a clock.
    rst = 1'b1;
    #1;
    check_snap(zero_exp("async_rst"));
    @(posedge clk);
    #1;
    check_snap(zero_exp("rst_hold"));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_snap(zero_exp("post_rst_idle"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
